// File: rtl/barrel_shifter_8bit.sv
// 8-bit rotate-right barrel shifter: three log-stage mux network (1, 2, 4)
// feeding an optional output register with a valid flag.
module barrel_shifter_8bit #(
    parameter int DATA_W  = 8,
    parameter int AMT_W   = 3,
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    // The mux network below is hand-wired for a byte; reject any other size.
    if (DATA_W != 8 || AMT_W != 3) begin : g_bad_width
        $error("barrel_shifter_8bit supports only DATA_W=8, AMT_W=3");
    end

    logic [7:0] s1_s;
    logic [7:0] s2_s;
    logic [7:0] s3_s;

    // Rotate-right network: each stage conditionally rotates by 1, 2 or 4.
    always_comb begin
        s1_s = data;
        s2_s = s1_s;
        s3_s = s2_s;
        if (amt[0]) begin
            s1_s = {data[0], data[7:1]};
        end else begin
            s1_s = data;
        end
        if (amt[1]) begin
            s2_s = {s1_s[1:0], s1_s[7:2]};
        end else begin
            s2_s = s1_s;
        end
        if (amt[2]) begin
            s3_s = {s2_s[3:0], s2_s[7:4]};
        end else begin
            s3_s = s2_s;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [7:0] out_r;
        logic       out_valid_r;

        // Output register: result captured only on valid input, held otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_r       <= 8'h00;
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= in_valid;
                if (in_valid) begin
                    out_r <= s3_s;
                end else begin
                    out_r <= out_r;
                end
            end
        end

        assign out       = out_r;
        assign out_valid = out_valid_r;
    end else begin : g_comb_out
        assign out       = s3_s;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_barrel_shifter_8bit.sv
// Scoreboard bench for barrel_shifter_8bit: stimulus pushes expected results,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_barrel_shifter_8bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] data;
    logic [2:0] amt;
    logic [7:0] out;
    logic       out_valid;

    logic [7:0] exp_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] last_exp;

    barrel_shifter_8bit #(
        .DATA_W (8),
        .AMT_W  (3),
        .REG_OUT(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .data     (data),
        .amt      (amt),
        .out      (out),
        .out_valid(out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: out[i] = d[(i+a) % 8], written independently of the mux network.
    function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic [2:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[(i + int'(a)) % 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        total_cnt++;
        if (act === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] a,
                         input logic [7:0] e, input bit push);
        @(negedge clk);
        in_valid = 1'b1;
        data     = d;
        amt      = a;
        if (push) begin
            exp_q.push_back(e);
            last_exp = e;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: one comparison per valid output, decoupled from stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_valid: out_valid=1 out=%h with no result pending", out);
                end else begin
                    check("result", out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sweep_exp[8];
        logic [7:0] walk_exp[8];
        logic [7:0] rd;
        logic [2:0] ra;

        sweep_exp = '{8'b00000011, 8'b10000001, 8'b11000000, 8'b01100000,
                      8'b00110000, 8'b00011000, 8'b00001100, 8'b00000110};
        walk_exp  = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        data     = 8'h00;
        amt      = 3'd0;
        last_exp = 8'h00;
        #2;
        check("reset_out", out, 8'h00);
        check("reset_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity, then asynchronous reset clears a held A5.
        drive(8'hA5, 3'd0, 8'hA5, 1'b1);
        idle();
        @(posedge clk);
        #1;
        check("hold_a5", out, 8'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, 8'h00);
        check("async_rst_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(8'b00000011, 3'(i), sweep_exp[i], 1'b1);
        end
        for (int i = 1; i < 8; i++) begin
            drive(8'h01, 3'(i), walk_exp[i], 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            drive(8'hFF, 3'(i), 8'hFF, 1'b1);
            drive(8'h00, 3'(i), 8'h00, 1'b1);
        end

        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            ra = 3'($urandom_range(0, 7));
            drive(rd, ra, rot_ref(rd, ra), 1'b1);
        end
        idle();
        @(posedge clk);
        #1;
        check("hold_last", out, last_exp);
        check("hold_valid", {7'b0, out_valid}, 8'h00);

        // Reset mid-stream: the first input is discarded, the second must follow.
        drive(8'h81, 3'd1, 8'hC0, 1'b0);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_valid", {7'b0, out_valid}, 8'h00);
        rst_n = 1'b1;
        drive(8'h3C, 3'd2, 8'h0F, 1'b1);
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
